// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK2 SPI reader: FSM states,
// packet geometry, LED command opcode and button bit positions.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_GAP    = 3'd4,
    ST_HOLD   = 3'd5
  } jstk_state_t;

  localparam int         JSTK_N_BYTES      = 5;
  localparam logic [7:0] JSTK_CMD_SET_LED  = 8'h84;
  localparam int         JSTK_BTN_JSTK_BIT = 0;
  localparam int         JSTK_BTN_TRIG_BIT = 1;

  // Byte transmitted at packet position idx when LED commands are enabled.
  function automatic logic [7:0] jstk_cmd_byte(input logic [2:0] idx, input logic [7:0] r,
                                                input logic [7:0] g, input logic [7:0] b);
    case (idx)
      3'd0:    return JSTK_CMD_SET_LED;
      3'd1:    return r;
      3'd2:    return g;
      3'd3:    return b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int jstk_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jstk_spi_if.sv
// SPI pin bundle between the joystick reader (master) and the PmodJSTK2 (slave).
interface jstk_spi_if;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output ss, output sclk, output mosi, input miso);
  modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_spi_byte.sv
// One-byte SPI mode-0 shifter: half-period counter, MSB-first TX/RX shift
// registers, and rise/fall/done strobes for the sequencing FSM.
module jstk_spi_byte #(
  parameter int HALF_SCLK = 750,
  parameter int CNT_W     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       run,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       rise,
  output logic       fall,
  output logic       done
);

  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [7:0]       tx_r;
  logic [7:0]       rx_r;
  logic             sclk_r;
  logic             half_end_s;

  assign half_end_s = (cnt_r == CNT_W'(HALF_SCLK - 1));
  assign rise       = run && !sclk_r && half_end_s;
  assign fall       = run &&  sclk_r && half_end_s;
  assign done       = fall && (bit_r == 3'd7);
  assign sclk       = sclk_r;
  assign mosi       = tx_r[7];
  assign rx_byte    = rx_r;

  // Half-period timing; miso is captured on the same edge that raises sclk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      bit_r  <= 3'd0;
      tx_r   <= 8'h00;
      rx_r   <= 8'h00;
      sclk_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= '0;
      bit_r  <= 3'd0;
      tx_r   <= tx_byte;
      sclk_r <= 1'b0;
    end else if (run) begin
      if (half_end_s) begin
        cnt_r <= '0;
        if (!sclk_r) begin
          sclk_r <= 1'b1;
          rx_r   <= {rx_r[6:0], miso};
        end else begin
          sclk_r <= 1'b0;
          tx_r   <= {tx_r[6:0], 1'b0};
          bit_r  <= bit_r + 3'd1;
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jstk_spi_reader.sv
// PmodJSTK2 packet reader: sequences setup, five bytes with gaps, and an idle
// hold around jstk_spi_byte. Optional LED command via JSTK_LED_CMD_EN.
module jstk_spi_reader
  import jstk_pkg::*;
#(
  parameter int HALF_SCLK = 750,
  parameter int T_SETUP   = 1500,
  parameter int T_GAP     = 1000,
  parameter int T_IDLE    = 2500,
  parameter int AXIS_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef JSTK_LED_CMD_EN
  input  logic [7:0]        led_r,
  input  logic [7:0]        led_g,
  input  logic [7:0]        led_b,
`endif
  jstk_spi_if.master        spi,
  output logic [AXIS_W-1:0] x_val,
  output logic [AXIS_W-1:0] y_val,
  output logic              btn_jstk,
  output logic              btn_trig,
  output logic              valid,
  output logic              busy
);

  localparam int MAX_T = jstk_max(jstk_max(HALF_SCLK, T_SETUP), jstk_max(T_GAP, T_IDLE));
  localparam int CNT_W = $clog2(MAX_T) + 1;
  localparam int HI_W  = AXIS_W - 8;

  jstk_state_t      state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       byte_idx_r;
  logic [7:0]       b0_r, b2_r;
  logic [HI_W-1:0]  b1_r, b3_r;
  logic             load_s, run_s, rise_s, fall_s, done_s, hold_entry_s;
  logic [7:0]       tx_s, first_tx_s, next_tx_s, rx_byte_s;
  logic             sclk_s, mosi_s;
  logic             ss_r, busy_r, valid_r, btn_jstk_r, btn_trig_r;
  logic [AXIS_W-1:0] x_val_r, y_val_r;

`ifdef JSTK_LED_CMD_EN
  logic [7:0] red_r, green_r, blue_r;

  // LED colour is frozen for the whole packet at the accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_r   <= 8'h00;
      green_r <= 8'h00;
      blue_r  <= 8'h00;
    end else if (state_r == ST_IDLE && start) begin
      red_r   <= led_r;
      green_r <= led_g;
      blue_r  <= led_b;
    end
  end

  assign first_tx_s = JSTK_CMD_SET_LED;
  assign next_tx_s  = jstk_cmd_byte(byte_idx_r + 3'd1, red_r, green_r, blue_r);
`else
  assign first_tx_s = 8'h00;
  assign next_tx_s  = 8'h00;
`endif

  assign run_s        = (state_r == ST_BIT_LO) || (state_r == ST_BIT_HI);
  assign hold_entry_s = (state_s == ST_HOLD) && (state_r != ST_HOLD);

  jstk_spi_byte #(.HALF_SCLK(HALF_SCLK), .CNT_W(CNT_W)) u_byte (
    .clk(clk), .rst(rst), .load(load_s), .tx_byte(tx_s), .run(run_s), .miso(spi.miso),
    .sclk(sclk_s), .mosi(mosi_s), .rx_byte(rx_byte_s), .rise(rise_s), .fall(fall_s),
    .done(done_s)
  );

  // Next-state logic; a byte is (re)loaded on accept and on every byte end.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    tx_s    = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SETUP;
          load_s  = 1'b1;
          tx_s    = first_tx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_W'(T_SETUP - 1)) state_s = ST_BIT_LO;
        else state_s = ST_SETUP;
      end
      ST_BIT_LO: begin
        if (rise_s) state_s = ST_BIT_HI;
        else state_s = ST_BIT_LO;
      end
      ST_BIT_HI: begin
        if (done_s) begin
          load_s = 1'b1;
          tx_s   = next_tx_s;
          if (byte_idx_r == 3'(JSTK_N_BYTES - 1)) state_s = ST_HOLD;
          else if (T_GAP == 0) state_s = ST_BIT_LO;
          else state_s = ST_GAP;
        end else if (fall_s) begin
          state_s = ST_BIT_LO;
        end else begin
          state_s = ST_BIT_HI;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_W'(T_GAP - 1)) state_s = ST_BIT_LO;
        else state_s = ST_GAP;
      end
      ST_HOLD: begin
        if (cnt_r == CNT_W'(T_IDLE)) state_s = ST_IDLE;
        else state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, phase counter, received bytes and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      byte_idx_r <= 3'd0;
      b0_r       <= 8'h00;
      b1_r       <= '0;
      b2_r       <= 8'h00;
      b3_r       <= '0;
      ss_r       <= 1'b1;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      x_val_r    <= '0;
      y_val_r    <= '0;
      btn_jstk_r <= 1'b0;
      btn_trig_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r || state_s == ST_IDLE) cnt_r <= '0;
      else cnt_r <= cnt_r + CNT_W'(1);

      if (state_r == ST_IDLE && start) byte_idx_r <= 3'd0;
      else if (done_s) byte_idx_r <= byte_idx_r + 3'd1;

      if (done_s) begin
        case (byte_idx_r)
          3'd0:    b0_r <= rx_byte_s;
          3'd1:    b1_r <= rx_byte_s[HI_W-1:0];
          3'd2:    b2_r <= rx_byte_s;
          3'd3:    b3_r <= rx_byte_s[HI_W-1:0];
          default: ;
        endcase
      end

      ss_r    <= (state_s == ST_IDLE) || (state_s == ST_HOLD);
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= hold_entry_s;
      // Last byte is still in the shifter on the edge that enters HOLD.
      if (hold_entry_s) begin
        x_val_r    <= {b1_r, b0_r};
        y_val_r    <= {b3_r, b2_r};
        btn_jstk_r <= rx_byte_s[JSTK_BTN_JSTK_BIT];
        btn_trig_r <= rx_byte_s[JSTK_BTN_TRIG_BIT];
      end
    end
  end

  assign spi.ss   = ss_r;
  assign spi.sclk = sclk_s;
  assign spi.mosi = mosi_s;
  assign x_val    = x_val_r;
  assign y_val    = y_val_r;
  assign btn_jstk = btn_jstk_r;
  assign btn_trig = btn_trig_r;
  assign valid    = valid_r;
  assign busy     = busy_r;

endmodule

// File: doc/jstk_spi_reader.md
# jstk_spi_reader

Parametrised SPI master for the PmodJSTK2 joystick. It replaces the fixed X-only reader with a single-clock-domain design that uses clock enables rather than a divided clock, and reads a full 5-byte packet. The packet gives both axes and both buttons, and each update is signalled by a one-cycle valid pulse. It sits between the board pins (`ss`, `sclk`, `miso`, `mosi`) and the servo steering logic, which consumes `x_val`/`y_val`.

## Interface
- `HALF_SCLK`, 750: `clk` cycles per SCLK half-period (100 MHz → 66.7 kHz SCLK).
- `T_SETUP`, 1500: cycles from `ss` falling to the first SCLK rising edge (15 µs).
- `T_GAP`, 1000: cycles of idle-low SCLK between bytes (10 µs).
- `T_IDLE`, 2500: minimum cycles `ss` stays high after a packet before the next `start` is accepted (25 µs).
- `AXIS_W`, 10: axis output width; upper bits come from the high byte, so the maximum is 16.
- `clk` input, 1: system clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `start` input, 1: request one packet; sampled only when `busy`=0.
- `miso` input, 1: serial data from the joystick.
- `ss` output, 1: slave select, active-low.
- `sclk` output, 1: SPI clock, mode 0, idles low.
- `mosi` output, 1: serial data to the joystick.
- `x_val` output, AXIS_W: X axis, registered.
- `y_val` output, AXIS_W: Y axis, registered.
- `btn_jstk` output, 1: joystick push-button.
- `btn_trig` output, 1: trigger button.
- `valid` output, 1: one-cycle pulse when the outputs update.
- `busy` output, 1: high from an accepted `start` through the end of `T_IDLE`.

## Operation
- **FSM states:** IDLE → SETUP → BIT_LO → BIT_HI → (GAP → BIT_LO | HOLD) → IDLE.
- **IDLE:**
  - `ss`=1, `sclk`=0, `busy`=0.
  - `start`=1 moves to SETUP, with `ss`=0 and `busy`=1 in the next cycle.
  - `start` pulses received while `busy`=1 are ignored, not queued.
- **SETUP:** waits `T_SETUP` cycles. MSB of byte 0 is already on `mosi` during this phase.
- **BIT_LO:** `sclk`=0 for `HALF_SCLK` cycles.
- **BIT_HI:**
  - On the rising SCLK edge, `miso` is shifted into the byte register, MSB first.
  - `sclk`=1 for `HALF_SCLK` cycles.
  - On the falling edge, `mosi` advances to the next bit.
- **Byte end:** after the 8th falling edge, byte index 0..3 goes to GAP (`T_GAP` cycles, then BIT_LO). Byte index 4 goes to HOLD.
- **HOLD:**
  - `ss`=1; outputs latch from the received bytes; `valid`=1 for exactly that cycle.
  - Waits `T_IDLE` cycles, then returns to IDLE.
- **Packet decode:**
  - b0 = X low, b1 = X high, b2 = Y low, b3 = Y high, b4 = buttons.
  - `x_val` = {b1[AXIS_W-9:0], b0}; `y_val` = {b3[AXIS_W-9:0], b2}; `btn_jstk` = b4[0]; `btn_trig` = b4[1].
- Outputs hold their last value between packets.

## Timing
- **Reset values:** `ss`=1, `sclk`=0, `mosi`=0, `x_val`=0, `y_val`=0, buttons 0, `valid`=0, `busy`=0, FSM in IDLE.
- **Mid-packet reset:** `ss` rises asynchronously and the partial packet is discarded. No `valid` is issued.
- **Packet length:** `start` to `valid` = 1 + `T_SETUP` + 40·2·`HALF_SCLK` + 4·`T_GAP` cycles.
- **Minimum start-to-start spacing:** packet length + `T_IDLE` + 1 cycles.
- **`miso` sampling:** sampled on the cycle `sclk` is driven high. Registered `sclk` makes the pin edge coincide with that sample.
- **Zero-length phases:** `T_GAP`=0 skips GAP; `T_SETUP`=0 is illegal (minimum 1).
- **Counters:** width = $clog2 of the largest timing parameter plus 1. No wrap-around is reachable.

## Configuration
- **`JSTK_LED_CMD_EN` defined:**
  - Adds inputs `led_r`, `led_g`, `led_b` (8 bits each), latched on an accepted `start`.
  - `mosi` sends b0=8'h84, b1=r, b2=g, b3=b, b4=8'h00, MSB first.
- **`JSTK_LED_CMD_EN` undefined:** LED ports are absent and `mosi` is held 0. The joystick treats this as a plain read.

## Structure
- **Package `jstk_pkg`:**
  - state enum `jstk_state_t`
  - `JSTK_N_BYTES`=5
  - `JSTK_CMD_SET_LED`=8'h84
  - button bit positions
- **Sub-module `jstk_spi_byte`:**
  - One-byte mode-0 shifter: SCLK half-period counter, 8-bit TX/RX shift registers, `done` pulse.
  - The top-level FSM sequences setup, gaps and hold around it.

## Test plan
- Reset with `HALF_SCLK`=2, `T_SETUP`=3, `T_GAP`=2, `T_IDLE`=4 → all outputs at reset values, `ss`=1, no SCLK activity.
- `start` pulse, slave model returns b0..b4 = 8'hFF, 8'h03, 8'h00, 8'h02, 8'h03 → `x_val`=10'h3FF, `y_val`=10'h200, both buttons 1, single `valid` pulse at the computed latency, `ss` rises in the same cycle.
- Check 40 SCLK rising edges, `T_GAP` low gaps between bytes, and `ss`=0 throughout.
- `start` held high for the whole packet → exactly one packet, and the next one begins only after `T_IDLE`.
- `rst` asserted at bit 17 → `ss`=1 and `sclk`=0 immediately, `x_val` unchanged at 0, no `valid`. A following `start` yields a correct full packet.
- With `JSTK_LED_CMD_EN`, `led_r`/`led_g`/`led_b`=8'h12/8'h34/8'h56 → `mosi` bytes captured on rising edges are 84,12,34,56,00. LED inputs changed mid-packet do not alter the transmitted bytes.
